sampler_dma_voice_engine: RTL and testbench

- Per-voice DMA read engine that sits directly downstream of the sampler DMA register block.
- Consumes one voice's dma_control/dma_base_addr words and produces that voice's dma_status/dma_curr_addr words.
- Fetches a sample buffer from memory: a length header word followed by 32-bit sample words. Buffers the words in a small FIFO and streams them to the voice mixer over a valid/ready handshake.
- One instance per voice; MAX_VOICES instances are generated at the top level.

---
 rtl/sampler_dma_pkg.sv | 24 ++
 rtl/sampler_dma_fifo.sv | 58 +++++
 rtl/sampler_dma_voice_engine.sv | 200 ++++++++++++++++++++
 tb/tb_sampler_dma_voice_engine.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_dma_pkg.sv
// Shared types and constants for the per-voice sampler DMA read engine.
package sampler_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrReq,
    StHdrWait,
    StStream,
    StDrain,
    StDone
  } dma_state_e;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_STOP     = 1;

  localparam int unsigned ST_BUSY       = 0;
  localparam int unsigned ST_DONE       = 1;
  localparam int unsigned ST_ERR_LEN0   = 2;
  localparam int unsigned ST_ABORTED    = 3;
  localparam int unsigned ST_REMAIN_LSB = 8;

  localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/sampler_dma_fifo.sv
// Show-ahead sample FIFO: rdata_o always presents the oldest word; flush empties it.
module sampler_dma_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sampler_dma_voice_engine.sv
// Per-voice DMA read engine: fetches a length header plus sample words and streams
// them to the mixer through a small show-ahead FIFO.
module sampler_dma_voice_engine
  import sampler_dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned MAX_LEN_BITS = 24
) (
  input  logic        axi_clk,
  input  logic        axi_reset,
  input  logic [31:0] dma_control,
  input  logic [31:0] dma_base_addr,
  output logic [31:0] dma_status,
  output logic [31:0] dma_curr_addr,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_gnt,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] sample_tdata,
  output logic        sample_tvalid,
  input  logic        sample_tready,
  output logic        sample_tlast
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

  dma_state_e              state_q, state_d;
  logic                    start_prev_q;
  logic [31:0]             base_q, base_d, curr_q, curr_d;
  logic [MAX_LEN_BITS-1:0] remain_q, remain_d, req_left_q, req_left_d;
  logic [CntW-1:0]         outst_q, outst_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d, abort_q, abort_d;

  logic                    start, stop, hdr_req, smp_req, issue, rd_accept;
  logic                    fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CntW-1:0]         fifo_count;
  logic [CntW:0]           occupancy;
  logic [31:0]             fifo_rdata;
  logic [MAX_LEN_BITS-1:0] hdr_len;
  logic                    unused_ctrl;

  assign unused_ctrl = ^{dma_control[31:2], fifo_full};

  assign start     = dma_control[CTRL_START] & ~start_prev_q;
  assign stop      = dma_control[CTRL_STOP];
  assign hdr_len   = mem_rd_data[MAX_LEN_BITS-1:0];
  // Words in flight plus words buffered never exceed the FIFO, so pushes cannot overflow.
  assign occupancy = {1'b0, outst_q} + {1'b0, fifo_count};
  assign hdr_req   = (state_q == StHdrReq);
  assign smp_req   = (state_q == StStream) && (req_left_q != '0) && (occupancy < DepthW);
  assign issue     = mem_rd_req & mem_rd_gnt;
  // Responses with nothing outstanding (e.g. stale after reset) are dropped.
  assign rd_accept = mem_rd_valid & (outst_q != '0);

  assign mem_rd_req    = hdr_req | smp_req;
  assign mem_rd_addr   = hdr_req ? base_q : (smp_req ? curr_q : '0);
  assign sample_tvalid = (state_q == StStream) & ~fifo_empty;
  assign sample_tdata  = sample_tvalid ? fifo_rdata : '0;
  assign sample_tlast  = sample_tvalid & (remain_q == MAX_LEN_BITS'(1));
  assign fifo_push     = rd_accept & (state_q == StStream);
  assign fifo_pop      = sample_tvalid & sample_tready;
  assign fifo_flush    = (state_q == StDrain);
  assign dma_curr_addr = curr_q;

  always_comb begin
    dma_status                     = '0;
    dma_status[31:ST_REMAIN_LSB]   = (32 - ST_REMAIN_LSB)'(remain_q);
    dma_status[ST_BUSY]            = busy_q;
    dma_status[ST_DONE]            = done_q;
    dma_status[ST_ERR_LEN0]        = err_q;
    dma_status[ST_ABORTED]         = abort_q;
  end

  always_comb begin
    unique case ({issue, rd_accept})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    curr_d     = curr_q;
    remain_d   = remain_q;
    req_left_d = req_left_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    abort_d    = abort_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StHdrReq;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          abort_d  = 1'b0;
          base_d   = dma_base_addr;
          curr_d   = dma_base_addr;
          remain_d = '0;
        end
      end
      StHdrReq: begin
        if (mem_rd_gnt)  state_d = StHdrWait;
        else if (stop)   state_d = StDrain;
      end
      StHdrWait: begin
        if (stop) begin
          state_d = StDrain;
        end else if (rd_accept) begin
          if (hdr_len == '0) begin
            state_d = StDone;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = StStream;
            remain_d   = hdr_len;
            req_left_d = hdr_len;
            curr_d     = base_q + ADDR_STEP;
          end
        end
      end
      StStream: begin
        if (issue) begin
          curr_d     = curr_q + ADDR_STEP;
          req_left_d = req_left_q - MAX_LEN_BITS'(1);
        end
        if (fifo_pop) remain_d = remain_q - MAX_LEN_BITS'(1);
        if (stop) begin
          state_d = StDrain;
        end else if (fifo_pop && (remain_q == MAX_LEN_BITS'(1))) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDrain: begin
        remain_d   = '0;
        req_left_d = '0;
        if (outst_q == '0) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          abort_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      base_q       <= '0;
      curr_q       <= '0;
      remain_q     <= '0;
      req_left_q   <= '0;
      outst_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= dma_control[CTRL_START];
      base_q       <= base_d;
      curr_q       <= curr_d;
      remain_q     <= remain_d;
      req_left_q   <= req_left_d;
      outst_q      <= outst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      abort_q      <= abort_d;
    end
  end

  sampler_dma_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32)
  ) u_fifo (
    .clk_i   (axi_clk),
    .rst_i   (axi_reset),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (mem_rd_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sampler_dma_voice_engine.sv
// Randomized bench for the sampler DMA voice engine against a transaction-level model.
module tb_sampler_dma_voice_engine;

  localparam int DEPTH = 8;

  logic        axi_clk = 1'b0;
  logic        axi_reset;
  logic [31:0] dma_control, dma_base_addr, dma_status, dma_curr_addr;
  logic        mem_rd_req, mem_rd_gnt, mem_rd_valid;
  logic [31:0] mem_rd_addr, mem_rd_data, sample_tdata;
  logic        sample_tvalid, sample_tready, sample_tlast;

  always #5 axi_clk = ~axi_clk;

  sampler_dma_voice_engine #(
    .FIFO_DEPTH   (DEPTH),
    .MAX_LEN_BITS (24)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_reset     (axi_reset),
    .dma_control   (dma_control),
    .dma_base_addr (dma_base_addr),
    .dma_status    (dma_status),
    .dma_curr_addr (dma_curr_addr),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_gnt    (mem_rd_gnt),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .sample_tdata  (sample_tdata),
    .sample_tvalid (sample_tvalid),
    .sample_tready (sample_tready),
    .sample_tlast  (sample_tlast)
  );

  typedef enum {PIdle, PHdr, PStream, PDrain, PDone} phase_e;

  int checks = 0;
  int errors = 0;

  // Memory image: explicit words, else a deterministic address hash.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  int          cyc = 0, last_due = 0;
  int          gnt_pct = 100, rdy_pct = 100, lat_lo = 2, lat_hi = 2;

  // Model of the current job.
  phase_e      phase = PIdle;
  logic [31:0] base, jb;
  int          len, jl, req_idx, ret, pops, drained, drain_cyc, tv_seen;
  logic        hdr_rx;
  logic [31:0] fin_st;
  logic        start_lvl = 1'b0, stop_lvl = 1'b0;
  logic [31:0] req_log [$];
  logic [31:0] dat_log [$];
  logic        last_log [$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_5A5A;
  endfunction

  function automatic int m_outs();
    return (req_idx > 0) ? (req_idx - 1 - ret) : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic   exp_req, exp_tv, exp_tl, take_req, take_val, take_pop;
    int     fcnt, due;
    phase_e was;
    @(negedge axi_clk);
    dma_control   = {30'd0, stop_lvl, start_lvl};
    mem_rd_gnt    = ($urandom_range(99) < gnt_pct);
    take_val      = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    mem_rd_valid  = take_val;
    mem_rd_data   = take_val ? word_at(pend_addr[0]) : $urandom;
    sample_tready = ($urandom_range(99) < rdy_pct);
    #1;
    if (phase == PDrain) begin
      if (dma_status[1]) begin
        chk("abort_status", dma_status, 32'h0000_000A);
        chk("drain_pending", pend_addr.size(), 0);
        phase  = PDone;
        fin_st = 32'h0000_000A;
      end else if (++drain_cyc > 200) begin
        chk("drain_timeout", 0, 1);
        phase = PDone;
      end
    end
    fcnt    = ret - pops;
    exp_req = (phase == PHdr) ? (req_idx == 0) :
              (phase == PStream) ? (req_idx <= len && (m_outs() + fcnt) < DEPTH) : 1'b0;
    chk("rd_req", mem_rd_req, exp_req);
    if (mem_rd_req && exp_req) chk("rd_addr", mem_rd_addr, base + 32'(4 * req_idx));
    exp_tv = (phase == PStream) && (fcnt > 0);
    exp_tl = exp_tv && (pops == len - 1);
    chk("tvalid", sample_tvalid, exp_tv);
    chk("tlast", sample_tlast, exp_tl);
    if (sample_tvalid && exp_tv) chk("tdata", sample_tdata, word_at(base + 32'(4 * (pops + 1))));
    unique case (phase)
      PIdle: begin
        chk("idle_status", dma_status, 32'h0);
        chk("idle_curr", dma_curr_addr, 32'h0);
      end
      PHdr:    chk("hdr_status", dma_status, 32'h1);
      PStream: begin
        chk("stream_status", dma_status, (32'(len - pops) << 8) | 32'h1);
        chk("stream_curr", dma_curr_addr, base + 32'(4 * req_idx));
      end
      PDone: begin
        chk("done_status", dma_status, fin_st);
        if (hdr_rx && len > 0) chk("done_curr", dma_curr_addr, base + 32'(4 * req_idx));
      end
      default: ;
    endcase
    if (sample_tvalid) tv_seen++;

    was      = phase;
    take_req = mem_rd_req & mem_rd_gnt;
    take_pop = sample_tvalid & sample_tready;
    if (take_req) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due < last_due) due = last_due;
      last_due = due;
      pend_addr.push_back(mem_rd_addr);
      pend_due.push_back(due);
      req_log.push_back(mem_rd_addr);
      req_idx++;
    end
    if (take_val) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      if (was == PHdr) begin
        hdr_rx = 1'b1;
        if (len == 0) begin
          phase  = PDone;
          fin_st = 32'h0000_0006;
        end else begin
          phase = PStream;
        end
      end else if (was == PStream) begin
        ret++;
      end else if (was == PDrain) begin
        drained++;
      end
    end
    if (take_pop && was == PStream) begin
      dat_log.push_back(sample_tdata);
      last_log.push_back(sample_tlast);
      pops++;
      if (pops == len) begin
        phase  = PDone;
        fin_st = 32'h0000_0002;
      end
    end
    if (stop_lvl && (was == PHdr || was == PStream)) begin
      phase     = PDrain;
      drain_cyc = 0;
    end
    if (start_lvl) begin
      start_lvl = 1'b0;
      phase     = PHdr;
      base      = jb;
      len       = jl;
      req_idx   = 0;
      ret       = 0;
      pops      = 0;
      drained   = 0;
      hdr_rx    = 1'b0;
    end
    cyc++;
  endtask

  task automatic job_start(input logic [31:0] b, input int l, input logic [7:0] hi);
    mem[b]        = {hi, 24'(l)};
    jb            = b;
    jl            = l;
    dma_base_addr = b;
    start_lvl     = 1'b1;
    tv_seen       = 0;
    req_log.delete();
    dat_log.delete();
    last_log.delete();
    step();
  endtask

  task automatic job_finish();
    for (int i = 0; i < 3000 && phase != PDone; i++) step();
    chk("job_done", phase == PDone, 1'b1);
    step();
    step();
  endtask

  initial begin
    axi_reset     = 1'b1;
    dma_control   = '0;
    dma_base_addr = '0;
    mem_rd_gnt    = 1'b0;
    mem_rd_valid  = 1'b0;
    mem_rd_data   = '0;
    sample_tready = 1'b0;
    step();
    step();
    axi_reset = 1'b0;
    step();

    // Directed: three words with 2-cycle memory latency.
    mem[32'h1004] = 32'hA;
    mem[32'h1008] = 32'hB;
    mem[32'h100C] = 32'hC;
    job_start(32'h1000, 3, 8'h00);
    job_finish();
    chk("t1_addr0", req_log[0], 32'h1000);
    chk("t1_addr1", req_log[1], 32'h1004);
    chk("t1_addr2", req_log[2], 32'h1008);
    chk("t1_addr3", req_log[3], 32'h100C);
    chk("t1_nreq", req_log.size(), 4);
    chk("t1_d0", dat_log[0], 32'hA);
    chk("t1_d1", dat_log[1], 32'hB);
    chk("t1_d2", dat_log[2], 32'hC);
    chk("t1_last", {last_log[0], last_log[1], last_log[2]}, 3'b001);
    chk("t1_status", dma_status, 32'h0000_0002);
    chk("t1_curr", dma_curr_addr, 32'h1010);

    // Zero-length header.
    job_start(32'h2000, 0, 8'h00);
    job_finish();
    chk("len0_status", dma_status, 32'h0000_0006);
    chk("len0_nreq", req_log.size(), 1);
    chk("len0_tvalid", tv_seen, 0);

    // Back-pressure: mixer stalled, requests must stop at FIFO depth.
    rdy_pct = 0;
    job_start(32'h4000, 20, 8'hFF);
    repeat (40) step();
    chk("bp_nreq", req_log.size(), 9);
    rdy_pct = 100;
    job_finish();
    chk("bp_nwords", dat_log.size(), 20);
    chk("bp_status", dma_status, 32'h0000_0002);

    // STOP with three sample reads in flight.
    lat_lo = 4;
    lat_hi = 4;
    rdy_pct = 50;
    job_start(32'h3000, 20, 8'h12);
    for (int i = 0; i < 100 && !(phase == PStream && m_outs() == 3); i++) step();
    chk("stop_reach3", m_outs(), 3);
    gnt_pct  = 0;
    stop_lvl = 1'b1;
    step();
    for (int i = 0; i < 100 && phase != PDone; i++) step();
    stop_lvl = 1'b0;
    gnt_pct  = 100;
    chk("stop_status", dma_status, 32'h0000_000A);
    chk("stop_drained", drained, 3);
    job_finish();

    // Address wrap.
    lat_lo = 1;
    lat_hi = 3;
    job_start(32'hFFFF_FFF8, 2, 8'h00);
    job_finish();
    chk("wrap_a1", req_log[1], 32'hFFFF_FFFC);
    chk("wrap_a2", req_log[2], 32'h0000_0000);
    chk("wrap_curr", dma_curr_addr, 32'h0000_0004);

    // Asynchronous reset in the middle of streaming, then a clean run.
    job_start(32'h5000, 30, 8'h00);
    repeat (15) step();
    #2;
    axi_reset    = 1'b1;
    mem_rd_valid = 1'b0;
    #1;
    chk("rst_req", mem_rd_req, 1'b0);
    chk("rst_addr", mem_rd_addr, 32'h0);
    chk("rst_tvalid", sample_tvalid, 1'b0);
    chk("rst_tdata", sample_tdata, 32'h0);
    chk("rst_tlast", sample_tlast, 1'b0);
    chk("rst_status", dma_status, 32'h0);
    chk("rst_curr", dma_curr_addr, 32'h0);
    @(negedge axi_clk);
    #1;
    axi_reset = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    last_due    = 0;
    phase       = PIdle;
    dma_control = '0;
    repeat (3) step();
    job_start(32'h6000, 5, 8'h00);
    job_finish();
    chk("post_rst_status", dma_status, 32'h0000_0002);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      gnt_pct = int'($urandom_range(100, 30));
      rdy_pct = int'($urandom_range(100, 20));
      lat_lo  = 1;
      lat_hi  = int'($urandom_range(4, 1));
      job_start($urandom & 32'hFFFF_FFFC, (j == 5) ? 0 : int'($urandom_range(24, 1)),
                8'($urandom));
      job_finish();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
